// File: rtl/calendar_pkg.sv
// Shared calendar constants, adjust-select encodings and BCD helpers.
// Leap-year detection exists only when CAL_LEAP_YEAR_EN is defined.
package calendar_pkg;

    typedef enum logic [1:0] {
        SEL_DAY  = 2'b00,
        SEL_MON  = 2'b01,
        SEL_YEAR = 2'b10,
        SEL_NONE = 2'b11
    } adj_sel_e;

    localparam logic [7:0] BCD_00 = 8'h00;
    localparam logic [7:0] BCD_01 = 8'h01;
    localparam logic [7:0] BCD_12 = 8'h12;
    localparam logic [7:0] BCD_28 = 8'h28;
    localparam logic [7:0] BCD_29 = 8'h29;
    localparam logic [7:0] BCD_30 = 8'h30;
    localparam logic [7:0] BCD_31 = 8'h31;
    localparam logic [7:0] BCD_99 = 8'h99;

    function automatic logic [7:0] bcd_inc(input logic [7:0] x);
        logic [7:0] r;
        if (x[3:0] == 4'h9) begin
            r = {x[7:4] + 4'h1, 4'h0};
        end else begin
            r = {x[7:4], x[3:0] + 4'h1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] x);
        logic [7:0] r;
        if (x[3:0] == 4'h0) begin
            r = {x[7:4] - 4'h1, 4'h9};
        end else begin
            r = {x[7:4], x[3:0] - 4'h1};
        end
        return r;
    endfunction

`ifdef CAL_LEAP_YEAR_EN
    // Year mod 4 on a BCD year: even tens need units 0/4/8, odd tens need 2/6.
    function automatic logic is_leap(input logic [7:0] y);
        logic r;
        if (y[4] == 1'b0) begin
            r = (y[3:0] == 4'h0) || (y[3:0] == 4'h4) || (y[3:0] == 4'h8);
        end else begin
            r = (y[3:0] == 4'h2) || (y[3:0] == 4'h6);
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/month_len_lut.sv
// Combinational month-length lookup: BCD month plus leap flag to BCD last day.
module month_len_lut
    import calendar_pkg::*;
(
    input  logic [7:0] mon,
    input  logic       leap,
    output logic [7:0] max_day
);

    // Month length table; unknown codes fall back to 31 so the day never overflows.
    always_comb begin
        max_day = BCD_31;
        case (mon)
            8'h02: begin
                if (leap) begin
                    max_day = BCD_29;
                end else begin
                    max_day = BCD_28;
                end
            end
            8'h04, 8'h06, 8'h09, 8'h11: max_day = BCD_30;
            default:                    max_day = BCD_31;
        endcase
    end

endmodule

// File: rtl/date_count.sv
// BCD day/month/year counter (2000-2099) with field adjust and century carry.
// Define CAL_LEAP_YEAR_EN to give February 29 days in leap years.
module date_count
    import calendar_pkg::*;
#(
    parameter logic [7:0] PAR_DAY_INIT  = 8'h01,
    parameter logic [7:0] PAR_MON_INIT  = 8'h01,
    parameter logic [7:0] PAR_YEAR_INIT = 8'h00
) (
    input  logic       I_SYS_CLK,
    input  logic       I_EXT_RST,
    input  logic       I_ADJ_UP,
    input  logic       I_ADJ_DOWN,
    input  logic [1:0] I_ADJ_SEL,
    input  logic       I_TRIG_F,
    output logic       O_TRIG_F,
    output logic [7:0] O_DAY,
    output logic [7:0] O_MON,
    output logic [7:0] O_YEAR
);

    logic [7:0] day_r, mon_r, year_r;
    logic       trig_r;
    logic [7:0] day_n_s, mon_n_s, year_n_s;
    logic       trig_n_s;
    logic [7:0] cur_len_s, adj_len_s;
    logic [7:0] adj_mon_s, adj_year_s;
    logic       leap_s, adj_leap_s;
    adj_sel_e   sel_s;

    assign sel_s = adj_sel_e'(I_ADJ_SEL);

`ifdef CAL_LEAP_YEAR_EN
    assign leap_s     = is_leap(year_r);
    assign adj_leap_s = is_leap(adj_year_s);
`else
    assign leap_s     = 1'b0;
    assign adj_leap_s = 1'b0;
`endif

    month_len_lut u_cur_len (
        .mon     (mon_r),
        .leap    (leap_s),
        .max_day (cur_len_s)
    );

    month_len_lut u_adj_len (
        .mon     (adj_mon_s),
        .leap    (adj_leap_s),
        .max_day (adj_len_s)
    );

    // Month/year as they would be after this cycle's month or year adjust.
    always_comb begin
        adj_mon_s  = mon_r;
        adj_year_s = year_r;
        if (I_ADJ_UP) begin
            case (sel_s)
                SEL_MON:  adj_mon_s  = (mon_r == BCD_12) ? BCD_01 : bcd_inc(mon_r);
                SEL_YEAR: adj_year_s = (year_r == BCD_99) ? BCD_00 : bcd_inc(year_r);
                default: begin
                    adj_mon_s  = mon_r;
                    adj_year_s = year_r;
                end
            endcase
        end else if (I_ADJ_DOWN) begin
            case (sel_s)
                SEL_MON:  adj_mon_s  = (mon_r == BCD_01) ? BCD_12 : bcd_dec(mon_r);
                SEL_YEAR: adj_year_s = (year_r == BCD_00) ? BCD_99 : bcd_dec(year_r);
                default: begin
                    adj_mon_s  = mon_r;
                    adj_year_s = year_r;
                end
            endcase
        end else begin
            adj_mon_s  = mon_r;
            adj_year_s = year_r;
        end
    end

    // Next-state: adjust beats the day-advance pulse; SEL_NONE still blocks it.
    always_comb begin
        day_n_s  = day_r;
        mon_n_s  = mon_r;
        year_n_s = year_r;
        trig_n_s = 1'b0;
        if (I_ADJ_UP || I_ADJ_DOWN) begin
            case (sel_s)
                SEL_DAY: begin
                    if (I_ADJ_UP) begin
                        day_n_s = (day_r >= cur_len_s) ? BCD_01 : bcd_inc(day_r);
                    end else begin
                        day_n_s = (day_r <= BCD_01) ? cur_len_s : bcd_dec(day_r);
                    end
                end
                SEL_MON, SEL_YEAR: begin
                    mon_n_s  = adj_mon_s;
                    year_n_s = adj_year_s;
                    day_n_s  = (day_r > adj_len_s) ? adj_len_s : day_r;
                end
                SEL_NONE: day_n_s = day_r;
                default:  day_n_s = day_r;
            endcase
        end else if (I_TRIG_F) begin
            if (day_r < cur_len_s) begin
                day_n_s = bcd_inc(day_r);
            end else begin
                day_n_s = BCD_01;
                if (mon_r == BCD_12) begin
                    mon_n_s = BCD_01;
                    if (year_r == BCD_99) begin
                        year_n_s = BCD_00;
                        trig_n_s = 1'b1;
                    end else begin
                        year_n_s = bcd_inc(year_r);
                    end
                end else begin
                    mon_n_s = bcd_inc(mon_r);
                end
            end
        end else begin
            day_n_s = day_r;
        end
    end

    // State register with synchronous reset overriding every other input.
    always_ff @(posedge I_SYS_CLK) begin
        if (I_EXT_RST) begin
            day_r  <= PAR_DAY_INIT;
            mon_r  <= PAR_MON_INIT;
            year_r <= PAR_YEAR_INIT;
            trig_r <= 1'b0;
        end else begin
            day_r  <= day_n_s;
            mon_r  <= mon_n_s;
            year_r <= year_n_s;
            trig_r <= trig_n_s;
        end
    end

    assign O_DAY    = day_r;
    assign O_MON    = mon_r;
    assign O_YEAR   = year_r;
    assign O_TRIG_F = trig_r;

endmodule

// File: tb/tb_date_count.sv
// Directed self-checking bench for date_count; expectations follow CAL_LEAP_YEAR_EN.
module tb_date_count;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up = 1'b0;
    logic       dn = 1'b0;
    logic [1:0] sel = 2'b11;
    logic       trig_in = 1'b0;
    logic       trig_out;
    logic [7:0] day, mon, year;
    int         checks = 0;
    int         failures = 0;

    date_count dut (
        .I_SYS_CLK  (clk),
        .I_EXT_RST  (rst),
        .I_ADJ_UP   (up),
        .I_ADJ_DOWN (dn),
        .I_ADJ_SEL  (sel),
        .I_TRIG_F   (trig_in),
        .O_TRIG_F   (trig_out),
        .O_DAY      (day),
        .O_MON      (mon),
        .O_YEAR     (year)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic u, input logic d, input logic t, input logic [1:0] s);
        up = u; dn = d; trig_in = t; sel = s;
        @(posedge clk);
        #1;
        up = 1'b0; dn = 1'b0; trig_in = 1'b0; sel = 2'b11;
    endtask

    task automatic chk(input string tag, input logic [7:0] ed, input logic [7:0] em,
                       input logic [7:0] ey, input logic et);
        checks++;
        assert ({day, mon, year, trig_out} === {ed, em, ey, et})
        else begin
            failures++;
            $error("FAIL %s: got %h/%h/%h trig=%b, expected %h/%h/%h trig=%b",
                   tag, day, mon, year, trig_out, ed, em, ey, et);
        end
    endtask

    // Walk to a date with adjust steps: year, then month, then day.
    task automatic set_date(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
        for (int i = 0; i < 100 && year !== y; i++) tick(1'b1, 1'b0, 1'b0, 2'b10);
        for (int i = 0; i < 12 && mon !== m; i++) tick(1'b1, 1'b0, 1'b0, 2'b01);
        for (int i = 0; i < 31 && day !== d; i++) tick(1'b1, 1'b0, 1'b0, 2'b00);
        chk("set_date", d, m, y, 1'b0);
    endtask

    initial begin
        // Reset with day-advance and adjust held high must still give defaults.
        rst = 1'b1; trig_in = 1'b1; up = 1'b1; sel = 2'b00;
        @(posedge clk); #1;
        chk("reset_busy", 8'h01, 8'h01, 8'h00, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; trig_in = 1'b0; up = 1'b0; sel = 2'b11;
        chk("reset_hold", 8'h01, 8'h01, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 2'b00);
        chk("idle", 8'h01, 8'h01, 8'h00, 1'b0);

        tick(1'b0, 1'b1, 1'b0, 2'b00);
        chk("day_down_wrap", 8'h31, 8'h01, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'b11);
        chk("end_of_jan", 8'h01, 8'h02, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 2'b01);
        chk("mon_down", 8'h01, 8'h01, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 2'b01);
        chk("mon_down_wrap", 8'h01, 8'h12, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 2'b10);
        chk("year_down_wrap", 8'h01, 8'h12, 8'h99, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 2'b10);
        chk("year_up_wrap", 8'h01, 8'h12, 8'h00, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 2'b01);
        chk("mon_up_wrap", 8'h01, 8'h01, 8'h00, 1'b0);

        set_date(8'h31, 8'h01, 8'h23);
        tick(1'b1, 1'b0, 1'b0, 2'b01);
        chk("clamp_feb23", 8'h28, 8'h02, 8'h23, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'b11);
        chk("feb28_23", 8'h01, 8'h03, 8'h23, 1'b0);

        set_date(8'h28, 8'h02, 8'h24);
        tick(1'b0, 1'b0, 1'b1, 2'b11);
`ifdef CAL_LEAP_YEAR_EN
        chk("feb28_24", 8'h29, 8'h02, 8'h24, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 2'b10);
        chk("clamp_feb25", 8'h28, 8'h02, 8'h25, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 2'b10);
        chk("back_feb24", 8'h28, 8'h02, 8'h24, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        chk("day_up_29", 8'h29, 8'h02, 8'h24, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'b11);
        chk("feb29_24", 8'h01, 8'h03, 8'h24, 1'b0);
`else
        chk("feb28_24_noleap", 8'h01, 8'h03, 8'h24, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 2'b00);
        chk("mar_down_day", 8'h31, 8'h03, 8'h24, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 2'b01);
        chk("clamp_feb24", 8'h28, 8'h02, 8'h24, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        chk("feb_day_wrap", 8'h01, 8'h02, 8'h24, 1'b0);
`endif

        set_date(8'h31, 8'h12, 8'h99);
        tick(1'b0, 1'b0, 1'b1, 2'b11);
        chk("century", 8'h01, 8'h01, 8'h00, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 2'b11);
        chk("century_pulse_end", 8'h01, 8'h01, 8'h00, 1'b0);

        set_date(8'h30, 8'h04, 8'h05);
        tick(1'b0, 1'b0, 1'b1, 2'b11);
        chk("apr30", 8'h01, 8'h05, 8'h05, 1'b0);

        set_date(8'h15, 8'h06, 8'h10);
        tick(1'b1, 1'b1, 1'b1, 2'b11);
        chk("sel_none_blocks", 8'h15, 8'h06, 8'h10, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 2'b00);
        chk("prio_up", 8'h16, 8'h06, 8'h10, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 2'b00);
        chk("prio_down", 8'h15, 8'h06, 8'h10, 1'b0);

        set_date(8'h30, 8'h06, 8'h10);
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        chk("day_up_wrap30", 8'h01, 8'h06, 8'h10, 1'b0);

        set_date(8'h09, 8'h07, 8'h10);
        tick(1'b0, 1'b0, 1'b1, 2'b11);
        chk("bcd_09_10", 8'h10, 8'h07, 8'h10, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 2'b00);
        chk("bcd_10_09", 8'h09, 8'h07, 8'h10, 1'b0);

        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 2'b11);
        rst = 1'b0;
        chk("reset_midrun", 8'h01, 8'h01, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'b11);
        chk("after_reset", 8'h02, 8'h01, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/date_count.md
DATE_COUNT -- requirements
Module: date_count

Interface
REQ-001 SHALL have parameter PAR_DAY_INIT, default 8'h01, BCD day loaded at reset.
REQ-002 SHALL have parameter PAR_MON_INIT, default 8'h01, BCD month loaded at reset.
REQ-003 SHALL have parameter PAR_YEAR_INIT, default 8'h00, BCD year (20YY) loaded at reset.
REQ-004 SHALL have ports:
- I_SYS_CLK  in  1  sole clock, rising edge.
- I_EXT_RST  in  1  synchronous, active-high reset.
- I_ADJ_UP  in  1  increment the selected field, one step per cycle high.
- I_ADJ_DOWN  in  1  decrement the selected field, one step per cycle high.
- I_ADJ_SEL  in  2  field select: 00 day, 01 month, 10 year, 11 none.
- I_TRIG_F  in  1  day-advance pulse from the hour counter's O_TRIG_F (23->00 carry).
- O_TRIG_F  out  1  one-cycle century carry (31 Dec 2099 -> 01 Jan 2000).
- O_DAY  out  8  BCD day, 01..month length.
- O_MON  out  8  BCD month, 01..12.
- O_YEAR  out  8  BCD year, 00..99.

Function
REQ-005 SHALL keep all outputs as registers updated only on the rising edge of I_SYS_CLK.
REQ-006 SHALL use input priority I_ADJ_UP > I_ADJ_DOWN > I_TRIG_F; a lower-priority input SHALL be ignored in any cycle where a higher-priority input is high.
REQ-007 SHALL compute month length from O_MON and the leap flag: 31 for months 01,03,05,07,08,10,12; 30 for months 04,06,09,11; 28 or 29 for month 02.
REQ-008 SHALL set the leap flag when year mod 4 == 0 (BCD: tens even and units in {0,4,8}, or tens odd and units in {2,6}).
REQ-009 SHALL, on I_TRIG_F with day < month length, increment the day by 1 in BCD (09->10, 19->20, 29->30).
REQ-010 SHALL, on I_TRIG_F with day == month length, set day to 01 and increment the month; month 12 SHALL wrap to 01 and increment the year.
REQ-011 SHALL, on I_TRIG_F at 31/12/99, load 01/01/00 and drive O_TRIG_F high for exactly that cycle.
REQ-012 SHALL drive O_TRIG_F low in every other cycle, including all adjust cycles.
REQ-013 SHALL, on a day adjust (I_ADJ_SEL=00), wrap up from month length to 01 and wrap down from 01 to month length.
REQ-014 SHALL, on a month adjust (I_ADJ_SEL=01), wrap up 12->01 and down 01->12; it SHALL NOT carry into the year.
REQ-015 SHALL, on a year adjust (I_ADJ_SEL=10), wrap up 99->00 and down 00->99; it SHALL NOT generate O_TRIG_F.
REQ-016 SHALL, after a month or year adjust, clamp the day to the length of the new month/year on the same clock edge (31/01 + month up -> 28/02 or 29/02).
REQ-017 SHALL take no action on adjust inputs when I_ADJ_SEL=11; I_TRIG_F SHALL still be blocked during those cycles.
REQ-018 SHALL produce no output change when no input is active.
REQ-019 SHALL keep every BCD digit within 0..9 at all times, with no illegal dates reachable from legal parameter values.

Reset
REQ-020 SHALL, while I_EXT_RST is high at a clock edge, load O_DAY=PAR_DAY_INIT, O_MON=PAR_MON_INIT, O_YEAR=PAR_YEAR_INIT and O_TRIG_F=0, overriding all other inputs.
REQ-021 SHALL, when reset coincides with I_TRIG_F or an adjust input, discard that event; normal operation SHALL resume on the first edge after reset is released.

Configuration
REQ-022 SHALL, with macro CAL_LEAP_YEAR_EN defined, give February 29 days when the leap flag is set and 28 otherwise.
REQ-023 SHALL, without CAL_LEAP_YEAR_EN, give February a fixed 28 days, force the leap flag to constant 0 and remove the leap-detection logic.

Structure
REQ-024 SHALL take the I_ADJ_SEL encodings (SEL_DAY, SEL_MON, SEL_YEAR, SEL_NONE) and BCD limit constants (8'h12, 8'h99, 8'h28, 8'h29, 8'h30, 8'h31) from the shared package calendar_pkg.
REQ-025 SHALL place the month-length logic in one combinational sub-module, month_len_lut, mapping (BCD month, leap flag) to a BCD maximum day, instantiated twice: once for the current month and once for the post-adjust month/year.

Verification
REQ-026 Reset with defaults -> 01/01/00, O_TRIG_F=0; with I_TRIG_F held high during reset -> still 01/01/00.
REQ-027 At 28/02/24 (CAL_LEAP_YEAR_EN defined), I_TRIG_F x2 -> 29/02/24, then 01/03/24; at 28/02/23 -> 01/03/23; without the macro, 28/02/24 -> 01/03/24.
REQ-028 At 31/12/99, I_TRIG_F -> 01/01/00 with a single-cycle O_TRIG_F pulse; at 30/04/05 -> 01/05/05 with O_TRIG_F=0.
REQ-029 At 31/01/23, month up -> 28/02/23; at 29/02/24, year up -> 28/02/25; at 01/01/00, day down -> 31/01/00.
REQ-030 I_ADJ_UP, I_ADJ_DOWN and I_TRIG_F all high with I_ADJ_SEL=00 at 15/06/10 -> 16/06/10 only; same inputs with I_ADJ_SEL=11 -> 15/06/10 unchanged.
